ec_datapath: RTL
================

Name: ec_datapath

Overview:
- Datapath for the 8-instruction accumulator CPU; sits directly downstream of the control unit and consumes its control word.
- Control word: IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub.
- Holds PC, IR, accumulator A and a 32x8 program/data RAM.
- Returns opcode IR[7:5], Aeq0 and Apos to the control unit. A program-load port lets a bench or host fill RAM while the CPU is held idle.

Parameters:
- ADDR_W, 5, address and PC width; RAM depth is 2**ADDR_W.
- DATA_W, 8, word, IR and accumulator width; must equal ADDR_W+3.

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- IRload  in  1  IR <= RAM read data.
- JMPmux  in  1  PC load source: 0 = PC+1, 1 = IR[ADDR_W-1:0].
- PCload  in  1  PC load enable.
- Meminst  in  1  RAM address select: 0 = PC, 1 = IR[ADDR_W-1:0].
- MemWr  in  1  RAM write of A at the selected address.
- Asel  in  2  A source: 00 = add/sub result, 01 = Input, 10 = RAM read data, 11 = 0.
- Aload  in  1  A load enable.
- Sub  in  1  ALU op: 0 = A+M, 1 = A-M.
- Input  in  DATA_W  external switch value for the input instruction.
- LoadEn  in  1  program-load write strobe.
- LoadAddr  in  ADDR_W  program-load address.
- LoadData  in  DATA_W  program-load data.
- IR  out  3  opcode IR[DATA_W-1:ADDR_W] to control unit.
- Aeq0  out  1  A == 0.
- Apos  out  1  ~A[DATA_W-1] (non-negative, zero included).
- Aout  out  DATA_W  accumulator value for display.
- PCout  out  ADDR_W  program counter for display.

Behaviour:
- Reset (synchronous, active-high) sets PC=0, IR=0, A=0, M (RAM read register)=0. RAM contents are not cleared.
- Outputs at reset: IR=000, Aeq0=1, Apos=1, Aout=0, PCout=0.
- RAM address addr = Meminst ? IR[ADDR_W-1:0] : PC, combinational.
- RAM read is synchronous: every edge M <= ram[addr], so one cycle of latency.
- M captures the pre-write (old) value when a write occurs at the same address on the same edge.
- RAM write priority on an edge:
  - LoadEn=1: ram[LoadAddr] <= LoadData; MemWr is ignored that cycle.
  - else MemWr=1: ram[addr] <= A.
- IRload=1: IR <= M.
- PCload=1: PC <= JMPmux ? IR[ADDR_W-1:0] : PC+1. PC+1 wraps 31 -> 0.
- Aload=1: A <= mux(Asel). ALU result is A+M or A-M, modulo 2**DATA_W, with no carry or overflow flag.
- Registers without an asserted load hold their value.
- Control-unit sequence timing:
  - start (Meminst=0): M <= ram[PC].
  - fetch: IR <= M, PC <= PC+1.
  - decode (Meminst=1): M <= ram[IR addr].
  - execute: load A <= M; add/sub A <= A±M; store writes A; input A <= Input; jz/jpos PC <= IR addr when PCload.
- Aeq0 and Apos are combinational from registered A, valid the cycle after any A update.
- Reset mid-instruction: registers clear on that edge and any write in that cycle is still performed. The control unit returns to start independently.
- Reset has priority over all loads except RAM writes.
- Simultaneous IRload and Aload: both registers update from pre-edge values.

Decomposition:
- Package ec_pkg holds:
  - opcode constants: LOAD=000, STORE=001, ADD=010, SUB=011, INPUT=100, JZ=101, JPOS=110, HALT=111.
  - Asel encodings: ASEL_ALU=00, ASEL_IN=01, ASEL_MEM=10, ASEL_ZERO=11.
  - defaults ADDR_W=5, DATA_W=8.
- One sub-module, ec_ram: single-port, synchronous-write, synchronous-read (registered M), with the load-port priority mux outside it.

Test Plan:
- Reset with A, PC and IR nonzero -> next cycle PC=0, IR=000, Aout=0, Aeq0=1, Apos=1; RAM word previously loaded with 8'h5A still reads 8'h5A.
- Load ram[0]=8'h1F, ram[31]=8'd7; drive start/fetch/decode, then load (Asel=10, Aload) -> IR=000, PCout=1, Aout=7.
- A=5, M=8'd9, Sub=1, Asel=00, Aload -> Aout=8'hFC, Aeq0=0, Apos=0. Then add with M=4 -> Aout=0, Aeq0=1, Apos=1.
- Store with IR addr=3, A=8'h42, MemWr=1 and LoadEn=1 to address 3 with 8'h99 in the same cycle -> ram[3]=8'h99. Next cycle with Meminst=0 at PC=3 -> M=8'h99.
- jz with IR=8'b101_01010: Aeq0=1 and PCload=1 -> PC=10; repeat with A=1 and PCload=0 -> PC unchanged.
- PC=31, PCload=1, JMPmux=0 -> PC=0. Input=8'h80 with Asel=01, Aload -> Aout=8'h80, Apos=0.

Source files
------------

// File: rtl/ec_pkg.sv
// Shared constants for the accumulator CPU datapath: opcodes, A-source select, widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package ec_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // Opcode field IR[DATA_W-1:ADDR_W] as decoded by the control unit
    typedef enum logic [2:0] {
        LOAD  = 3'b000,
        STORE = 3'b001,
        ADD   = 3'b010,
        SUB   = 3'b011,
        INPUT = 3'b100,
        JZ    = 3'b101,
        JPOS  = 3'b110,
        HALT  = 3'b111
    } opcode_e;

    // Accumulator load source
    typedef enum logic [1:0] {
        ASEL_ALU  = 2'b00,
        ASEL_IN   = 2'b01,
        ASEL_MEM  = 2'b10,
        ASEL_ZERO = 2'b11
    } asel_e;

endpackage

// File: rtl/ec_datapath_if.sv
// Control word, program-load port and status returned between control unit and datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the control unit owns all sequencing.
interface ec_datapath_if #(
    parameter int ADDR_W = ec_pkg::ADDR_W,
    parameter int DATA_W = ec_pkg::DATA_W
);
    // control word
    logic              ir_load;
    logic              jmp_mux;
    logic              pc_load;
    logic              mem_inst;
    logic              mem_wr;
    logic [1:0]        asel;
    logic              a_load;
    logic              sub;
    // external switches and program-load port
    logic [DATA_W-1:0] in_dat;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_dat;
    // status / display back to the control unit and host
    logic [2:0]        ir_op;
    logic              a_eq0;
    logic              a_pos;
    logic [DATA_W-1:0] a_out;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output ir_load, jmp_mux, pc_load, mem_inst, mem_wr, asel, a_load, sub,
        output in_dat, load_en, load_addr, load_dat,
        input  ir_op, a_eq0, a_pos, a_out, pc_out
    );

    modport slave (
        input  ir_load, jmp_mux, pc_load, mem_inst, mem_wr, asel, a_load, sub,
        input  in_dat, load_en, load_addr, load_dat,
        output ir_op, a_eq0, a_pos, a_out, pc_out
    );

endinterface

// File: rtl/ec_ram.sv
// Program/data RAM: one write port, one registered read port (M).
// Latency: read data appears in M one edge after the address; reads return pre-write data.
// Backpressure: none; accepts a write and a read every cycle.
module ec_ram
    import ec_pkg::*;
#(
    parameter int ADDR_W = ec_pkg::ADDR_W,
    parameter int DATA_W = ec_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdat_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] m_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] m_q;

    // Storage write; deliberately not reset so program contents survive a CPU reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
    end

    // Registered read; non-blocking update means a same-edge write is not yet visible
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q <= '0;
        end else begin
            m_q <= mem_q[raddr_i];
        end
    end

    assign m_o = m_q;

endmodule

// File: rtl/ec_datapath.sv
// Accumulator CPU datapath: PC, IR, A, ALU and the program/data RAM.
// Latency: register loads take effect on the next edge; RAM reads land in M one edge later.
// Backpressure: none; every control word is acted on in the cycle it is presented.
module ec_datapath
    import ec_pkg::*;
#(
    parameter int ADDR_W = ec_pkg::ADDR_W,
    parameter int DATA_W = ec_pkg::DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ec_datapath_if.slave  dp
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q,  a_d;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdat;

    // Instruction operand field doubles as memory address and jump target
    assign addr = dp.mem_inst ? ir_q[ADDR_W-1:0] : pc_q;

    // Host program-load port wins over a CPU store in the same cycle
    assign ram_we    = dp.load_en | dp.mem_wr;
    assign ram_waddr = dp.load_en ? dp.load_addr : addr;
    assign ram_wdat  = dp.load_en ? dp.load_dat  : a_q;

    ec_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdat_i  (ram_wdat),
        .raddr_i (addr),
        .m_o     (m)
    );

    // Wrapping add/subtract; no carry or overflow is kept
    assign alu = dp.sub ? (a_q - m) : (a_q + m);

    // Next-state selection for PC, IR and A; all sources are pre-edge values
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        a_d  = a_q;
        if (dp.pc_load) begin
            pc_d = dp.jmp_mux ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
        end
        if (dp.ir_load) begin
            ir_d = m;
        end
        if (dp.a_load) begin
            case (asel_e'(dp.asel))
                ASEL_ALU:  a_d = alu;
                ASEL_IN:   a_d = dp.in_dat;
                ASEL_MEM:  a_d = m;
                default:   a_d = '0;
            endcase
        end
    end

    // Architectural registers; reset overrides every load
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
            ir_q <= '0;
            a_q  <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
        end
    end

    assign dp.ir_op  = ir_q[DATA_W-1:ADDR_W];
    assign dp.a_eq0  = (a_q == '0);
    assign dp.a_pos  = ~a_q[DATA_W-1];
    assign dp.a_out  = a_q;
    assign dp.pc_out = pc_q;

endmodule
